// File: rtl/vga_pkg.sv
// Shared timing constants and capture state encoding for the VGA capture path.
// Defaults describe 800x600@60 with a 40 MHz pixel clock.
package vga_pkg;

    localparam int H_TOTAL  = 1056;
    localparam int V_TOTAL  = 628;
    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;
    localparam int CW       = 11;
    localparam int FW       = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DONE
    } cap_state_t;

endpackage

// File: rtl/vga_pos_tracker.sv
// Free-running expected raster position, realigned on a frame boundary while armed,
// compared against the timing generator's counters.
module vga_pos_tracker #(
    parameter int H_TOTAL = vga_pkg::H_TOTAL,
    parameter int V_TOTAL = vga_pkg::V_TOTAL,
    parameter int CW      = vga_pkg::CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] hcount_in,
    input  logic [CW-1:0] vcount_in,
    output logic          mismatch,
    output logic          fb,
    output logic          fe,
    output logic          out_of_range
);

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    logic [CW-1:0] exp_h;
    logic [CW-1:0] exp_v;
    logic [CW-1:0] base_h;
    logic [CW-1:0] base_v;
    logic [CW-1:0] nxt_h;
    logic [CW-1:0] nxt_v;

    assign fb = (hcount_in == '0) && (vcount_in == '0);
    assign fe = (hcount_in == H_LAST) && (vcount_in == V_LAST);

    // Extra bit keeps the bound compare correct even when H_TOTAL fills the counter width.
    assign out_of_range = ({1'b0, hcount_in} >= (CW+1)'(H_TOTAL)) ||
                          ({1'b0, vcount_in} >= (CW+1)'(V_TOTAL));

    assign mismatch = (hcount_in != exp_h) || (vcount_in != exp_v);

    always_comb begin
        base_h = exp_h;
        base_v = exp_v;
        if (load && fb) begin
            base_h = '0;
            base_v = '0;
        end
        nxt_h = base_h + 1'b1;
        nxt_v = base_v;
        if (base_h == H_LAST) begin
            nxt_h = '0;
            nxt_v = (base_v == V_LAST) ? '0 : base_v + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_h <= '0;
            exp_v <= '0;
        end else begin
            exp_h <= nxt_h;
            exp_v <= nxt_v;
        end
    end

endmodule

// File: rtl/vga_capture_ctrl.sv
// Frame capture sequencer: arms on start, aligns to the next frame boundary and
// gates N whole frames, aborting on any raster inconsistency.
//
// state   | meaning
// IDLE    | waiting for start; frames_left held at 0
// ARM     | request latched, waiting for hcount/vcount = (0,0)
// CAPTURE | gating pixels, raster checked against the expected position every cycle
// DONE    | last frame finished; issues the done pulse and returns to IDLE
module vga_capture_ctrl #(
    parameter int H_TOTAL  = vga_pkg::H_TOTAL,
    parameter int V_TOTAL  = vga_pkg::V_TOTAL,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int CW       = vga_pkg::CW,
    parameter int FW       = vga_pkg::FW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [FW-1:0] num_frames,
    input  logic          abort,
    input  logic [CW-1:0] hcount_in,
    input  logic [CW-1:0] vcount_in,
    output logic          go,
    output logic          pix_valid,
    output logic          frame_start,
    output logic          frame_done,
    output logic          busy,
    output logic          done,
    output logic [FW-1:0] frames_left,
    output logic          sync_err
);

    import vga_pkg::*;

    cap_state_t    state;
    cap_state_t    state_nxt;
    logic [FW-1:0] frames_left_nxt;
    logic [FW-1:0] req_frames;
    logic          sync_err_nxt;
    logic          frame_start_nxt;
    logic          frame_done_nxt;
    logic          done_nxt;
    logic          active_px;
    logic          mismatch;
    logic          fb;
    logic          fe;
    logic          out_of_range;

    vga_pos_tracker #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .CW      (CW)
    ) u_pos_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (state == ARM),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .mismatch     (mismatch),
        .fb           (fb),
        .fe           (fe),
        .out_of_range (out_of_range)
    );

    assign req_frames = (num_frames == '0) ? FW'(1) : num_frames;
    assign active_px  = ({1'b0, hcount_in} < (CW+1)'(H_ACTIVE)) &&
                        ({1'b0, vcount_in} < (CW+1)'(V_ACTIVE));

    always_comb begin
        state_nxt       = state;
        frames_left_nxt = frames_left;
        sync_err_nxt    = sync_err;
        frame_start_nxt = 1'b0;
        frame_done_nxt  = 1'b0;
        done_nxt        = 1'b0;
        if (abort) begin
            state_nxt       = IDLE;
            frames_left_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt       = ARM;
                        frames_left_nxt = req_frames;
                        sync_err_nxt    = 1'b0;
                    end
                end
                ARM: begin
                    // Garbage counters before alignment only flag the error; arming continues.
                    if (out_of_range) begin
                        sync_err_nxt = 1'b1;
                    end else if (fb) begin
                        state_nxt       = CAPTURE;
                        frame_start_nxt = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (mismatch || out_of_range) begin
                        state_nxt       = IDLE;
                        sync_err_nxt    = 1'b1;
                        frames_left_nxt = '0;
                    end else if (fe) begin
                        frame_done_nxt = 1'b1;
                        if (frames_left <= FW'(1)) begin
                            state_nxt       = DONE;
                            frames_left_nxt = '0;
                        end else begin
                            frames_left_nxt = frames_left - 1'b1;
                        end
                    end else if (fb) begin
                        frame_start_nxt = 1'b1;
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
                default: begin
                    state_nxt       = IDLE;
                    frames_left_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            go          <= 1'b0;
            busy        <= 1'b0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            done        <= 1'b0;
            frames_left <= '0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            go          <= (state_nxt == CAPTURE);
            busy        <= (state_nxt == ARM) || (state_nxt == CAPTURE);
            pix_valid   <= (state_nxt == CAPTURE) && active_px;
            frame_start <= frame_start_nxt;
            frame_done  <= frame_done_nxt;
            done        <= done_nxt;
            frames_left <= frames_left_nxt;
            sync_err    <= sync_err_nxt;
        end
    end

endmodule

// File: tb/tb_vga_capture_ctrl.sv
// Randomized and directed bench for vga_capture_ctrl on a shrunken raster; expected
// outputs come from frame-offset arithmetic relative to the aligning (0,0).
module tb_vga_capture_ctrl;

    localparam int HT = 16;
    localparam int VT = 10;
    localparam int HA = 12;
    localparam int VA = 7;
    localparam int CW = 11;
    localparam int FW = 8;
    localparam int FL = HT * VT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [FW-1:0] num_frames = '0;
    logic          abort = 1'b0;
    logic [CW-1:0] hcount_in = '0;
    logic [CW-1:0] vcount_in = '0;
    logic          go;
    logic          pix_valid;
    logic          frame_start;
    logic          frame_done;
    logic          busy;
    logic          done;
    logic [FW-1:0] frames_left;
    logic          sync_err;

    always #5 clk = ~clk;

    vga_capture_ctrl #(
        .H_TOTAL  (HT),
        .V_TOTAL  (VT),
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .CW       (CW),
        .FW       (FW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_frames  (num_frames),
        .abort       (abort),
        .hcount_in   (hcount_in),
        .vcount_in   (vcount_in),
        .go          (go),
        .pix_valid   (pix_valid),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy),
        .done        (done),
        .frames_left (frames_left),
        .sync_err    (sync_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gen_p = 0;

    // Reference capture: running flag, effective frame count, cycle of the aligning (0,0).
    bit m_run = 1'b0;
    bit m_serr = 1'b0;
    int m_n = 0;
    int m_cfb = -1;

    int pv_cnt, fs_cnt, fd_cnt, dn_cnt, last_fs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input bit st, input int nf, input bit ab, input bit rs, input int h_ov);
        int h, v, k, w, p;
        bit oor;
        bit e_go, e_pv, e_fs, e_fd, e_busy, e_done;
        int e_fl;
        h = (h_ov >= 0) ? h_ov : gen_p % HT;
        v = gen_p / HT;
        start      = st;
        num_frames = FW'(nf);
        abort      = ab;
        rst_n      = !rs;
        hcount_in  = CW'(h);
        vcount_in  = CW'(v);
        e_go = 0; e_pv = 0; e_fs = 0; e_fd = 0; e_busy = 0; e_done = 0; e_fl = 0;
        oor = (h >= HT) || (v >= VT);
        if (rs) begin
            m_run  = 1'b0;
            m_serr = 1'b0;
        end else if (!m_run) begin
            if (st && !ab) begin
                m_run  = 1'b1;
                m_n    = (nf == 0) ? 1 : nf;
                m_cfb  = -1;
                m_serr = 1'b0;
                e_busy = 1'b1;
                e_fl   = m_n;
            end
        end else if (ab) begin
            m_run = 1'b0;
        end else begin
            if (m_cfb < 0) begin
                if (oor) m_serr = 1'b1;
                else if (h == 0 && v == 0) m_cfb = cyc;
            end
            if (m_cfb < 0) begin
                e_busy = 1'b1;
                e_fl   = m_n;
            end else begin
                k = cyc - m_cfb;
                w = m_n * FL;
                p = k % FL;
                if (k >= 1 && k <= w - 1 && (oor || h != p % HT || v != p / HT)) begin
                    m_serr = 1'b1;
                    m_run  = 1'b0;
                end else if (k <= w - 2) begin
                    e_go   = 1'b1;
                    e_busy = 1'b1;
                    e_fs   = (p == 0);
                    e_fd   = (p == FL - 1);
                    e_fl   = m_n - (k + 1) / FL;
                    e_pv   = (p % HT < HA) && (p / HT < VA);
                end else if (k == w - 1) begin
                    e_fd = 1'b1;
                end else begin
                    e_done = 1'b1;
                    m_run  = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        check_eq("go", go, e_go);
        check_eq("pix_valid", pix_valid, e_pv);
        check_eq("frame_start", frame_start, e_fs);
        check_eq("frame_done", frame_done, e_fd);
        check_eq("busy", busy, e_busy);
        check_eq("done", done, e_done);
        check_eq("frames_left", frames_left, e_fl);
        check_eq("sync_err", sync_err, m_serr);
        if (pix_valid === 1'b1) pv_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
        if (done === 1'b1) dn_cnt++;
        if (frame_start === 1'b1) begin
            if (fs_cnt > 0) check_eq("fs_spacing", cyc - last_fs, FL);
            last_fs = cyc;
            fs_cnt++;
        end
        cyc++;
        gen_p = (gen_p + 1) % FL;
    endtask

    task automatic idle_until(input int pos);
        int g;
        g = 0;
        while (gen_p != pos && g < FL) begin
            tick(0, 0, 0, 0, -1);
            g++;
        end
    endtask

    // act: 0 none, 1 abort at k, 2 raster skip at k, 3 start at k,
    //      4 reset at k, 5 out-of-range h on the at-th armed cycle
    task automatic run_capture(input int nf, input int act, input int at);
        int guard, kn;
        bit ab, rs, st;
        int ho;
        pv_cnt = 0; fs_cnt = 0; fd_cnt = 0; dn_cnt = 0; last_fs = 0;
        tick(1, nf, 0, 0, -1);
        guard = 0;
        while (m_run && guard < 6 * FL + 50) begin
            ab = 0; rs = 0; st = 0; ho = -1;
            kn = (m_cfb >= 0) ? cyc - m_cfb : -1;
            if (m_cfb >= 0 && kn == at) begin
                case (act)
                    1: ab = 1;
                    2: gen_p = (gen_p + 1) % FL;
                    3: st = 1;
                    4: rs = 1;
                    default: ;
                endcase
            end
            if (act == 5 && m_cfb < 0 && guard == at) ho = HT + 3;
            tick(st, nf, ab, rs, ho);
            guard++;
        end
        check_eq("capture_bound", guard < 6 * FL + 50, 1);
        tick(0, 0, 0, 0, -1);
    endtask

    initial begin
        int gap, nf, act, w, at;
        repeat (3) tick(0, 0, 0, 1, -1);
        repeat (2) tick(0, 0, 0, 0, -1);

        // single frame armed mid-frame
        idle_until(4 * HT + 7);
        run_capture(1, 0, 0);
        check_eq("nom_pix_cnt", pv_cnt, HA * VA);
        check_eq("nom_fs_cnt", fs_cnt, 1);
        check_eq("nom_fd_cnt", fd_cnt, 1);
        check_eq("nom_done_cnt", dn_cnt, 1);

        idle_until(37);
        run_capture(3, 0, 0);
        check_eq("multi_fs_cnt", fs_cnt, 3);
        check_eq("multi_fd_cnt", fd_cnt, 3);
        check_eq("multi_done_cnt", dn_cnt, 1);
        check_eq("multi_pix_cnt", pv_cnt, 3 * HA * VA);

        idle_until(90);
        run_capture(0, 0, 0);
        check_eq("zero_fs_cnt", fs_cnt, 1);
        check_eq("zero_done_cnt", dn_cnt, 1);

        // h jumps 5 -> 7 on line 3 of frame 1 of 2
        run_capture(2, 2, 3 * HT + 6);
        check_eq("glitch_serr", sync_err, 1);
        check_eq("glitch_fd_cnt", fd_cnt, 0);
        check_eq("glitch_done_cnt", dn_cnt, 0);
        run_capture(1, 0, 0);
        check_eq("restart_done_cnt", dn_cnt, 1);

        idle_until(20);
        run_capture(2, 5, 3);
        check_eq("arm_oor_serr", sync_err, 1);
        check_eq("arm_oor_done_cnt", dn_cnt, 1);

        // abort coincident with the end of frame 2 of 3
        run_capture(3, 1, 2 * FL - 1);
        check_eq("abort_fd_cnt", fd_cnt, 1);
        check_eq("abort_done_cnt", dn_cnt, 0);

        tick(1, 2, 1, 0, -1);
        tick(0, 0, 0, 0, -1);

        run_capture(1, 3, FL);
        check_eq("done_start_done_cnt", dn_cnt, 1);

        run_capture(2, 4, FL + 20);
        check_eq("reset_done_cnt", dn_cnt, 0);

        for (int i = 0; i < 30; i++) begin
            gap = $urandom_range(0, FL - 1);
            repeat (gap) tick(0, 0, 0, 0, -1);
            nf  = $urandom_range(0, 3);
            act = $urandom_range(0, 5);
            w   = ((nf == 0) ? 1 : nf) * FL;
            case (act)
                2: at = $urandom_range(1, w - 1);
                5: at = $urandom_range(0, 8);
                default: at = $urandom_range(0, w);
            endcase
            run_capture(nf, act, at);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
